// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: shares a single binary-to-BCD converter among N_REQ
// requesters. Requests are picked round-robin and one conversion runs at a
// time. The block sequences the converter's start/ready/done handshake, returns
// the digits to the granted requester, and uses a watchdog to release the
// converter if done never arrives.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | no conversion in flight; grant when a request is pending and the
//        | converter reports ready
// ISSUE  | one-cycle conv_start pulse carrying the latched operand
// WAIT   | wait for conv_done; the watchdog aborts after TIMEOUT_CYCLES
module bcd_conv_arbiter #(
  parameter int N_REQ          = 4,
  parameter int DATA_WIDTH     = 26,
  parameter int DIGITS         = 8,
  parameter int TIMEOUT_CYCLES = 127
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            resp_valid,
  output logic                        resp_err,
  output logic [DIGITS*4-1:0]         resp_bcd,
  output logic                        busy,
  output logic [2:0]                  grant_id,
  output logic                        conv_start,
  output logic [DATA_WIDTH-1:0]       conv_binary_value,
  input  logic                        conv_ready,
  input  logic                        conv_done,
  input  logic [DIGITS*4-1:0]         conv_bcd
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]           grant_q, grant_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   op_q, op_d;
  logic [N_REQ-1:0]        resp_valid_q, resp_valid_d;
  logic                    resp_err_q, resp_err_d;
  logic [DIGITS*4-1:0]     resp_bcd_q, resp_bcd_d;

  logic [DATA_WIDTH-1:0]   op_arr [N_REQ];
  logic                    pick_found;
  logic [PW-1:0]           pick_idx;
  logic [PW-1:0]           grant_nxt;
  logic [CW-1:0]           cnt_inc;

  // Unpack the flattened operand bus so the granted slot can be indexed directly
  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign op_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search: first pending requester at or after rr_ptr, wrapping
  always_comb begin
    int j;
    logic [PW-1:0] idx;
    j          = 0;
    idx        = '0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= N_REQ) j = j - N_REQ;
      idx = PW'(j);
      if (!pick_found && req_valid[idx]) begin
        pick_found = 1'b1;
        pick_idx   = idx;
      end
    end
  end

  assign grant_nxt = (grant_q == PW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
  assign cnt_inc   = cnt_q + 1'b1;

  // Next-state, handshake pulses and result capture
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    resp_valid_d = '0;
    resp_err_d   = 1'b0;
    resp_bcd_d   = resp_bcd_q;
    req_ready    = '0;
    unique case (state_q)
      S_IDLE: begin
        // rst gating keeps the combinational accept pulse low while in reset
        if (pick_found && conv_ready && !rst) begin
          req_ready[pick_idx] = 1'b1;
          grant_d             = pick_idx;
          op_d                = op_arr[pick_idx];
          state_d             = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // done takes priority over a watchdog expiry in the same cycle
        if (conv_done) begin
          resp_bcd_d            = conv_bcd;
          resp_valid_d[grant_q] = 1'b1;
          rr_ptr_d              = grant_nxt;
          state_d               = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(TIMEOUT_CYCLES)) begin
            resp_bcd_d            = '0;
            resp_valid_d[grant_q] = 1'b1;
            resp_err_d            = 1'b1;
            rr_ptr_d              = grant_nxt;
            state_d               = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any conversion silently
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      cnt_q        <= '0;
      op_q         <= '0;
      resp_valid_q <= '0;
      resp_err_q   <= 1'b0;
      resp_bcd_q   <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_bcd_q   <= resp_bcd_d;
    end
  end

  assign resp_valid        = resp_valid_q;
  assign resp_err          = resp_err_q;
  assign resp_bcd          = resp_bcd_q;
  assign busy              = (state_q != S_IDLE);
  assign grant_id          = 3'(grant_q);
  assign conv_start        = (state_q == S_ISSUE);
  assign conv_binary_value = op_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Testbench for bcd_conv_arbiter: behavioural converter model, scoreboard of
// expected responses filled at accept time, table-driven round-robin vectors
// and hand-written sequences for timeout, collision, reset and busy cases.
module tb_bcd_conv_arbiter;

  localparam int N  = 4;
  localparam int DW = 26;
  localparam int LAT = 30;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready, resp_valid;
  logic            resp_err, busy, conv_start, conv_ready, conv_done;
  logic [31:0]     resp_bcd, conv_bcd;
  logic [2:0]      grant_id;
  logic [DW-1:0]   conv_binary_value;

  bcd_conv_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .DIGITS(8), .TIMEOUT_CYCLES(127)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_bcd(resp_bcd), .busy(busy), .grant_id(grant_id), .conv_start(conv_start),
    .conv_binary_value(conv_binary_value), .conv_ready(conv_ready),
    .conv_done(conv_done), .conv_bcd(conv_bcd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] to_bcd(logic [DW-1:0] v);
    logic [31:0] r;
    int x;
    r = '0;
    x = int'(v);
    for (int d = 0; d < 8; d++) begin
      r[d*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // converter model
  logic          suppress = 1'b0, force_nr = 1'b0, inj_done = 1'b0;
  logic [31:0]   inj_bcd = '0;
  logic          cm_busy, cm_done;
  logic [5:0]    cm_cnt;
  logic [DW-1:0] cm_val;
  logic [31:0]   cm_bcd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cm_busy <= 1'b0; cm_done <= 1'b0; cm_cnt <= '0; cm_val <= '0; cm_bcd <= '0;
    end else begin
      cm_done <= 1'b0;
      if (cm_busy) begin
        if (cm_cnt == 0) begin
          cm_busy <= 1'b0;
          if (!suppress) begin
            cm_done <= 1'b1;
            cm_bcd  <= to_bcd(cm_val);
          end
        end else cm_cnt <= cm_cnt - 1'b1;
      end else if (conv_start) begin
        cm_busy <= 1'b1;
        cm_cnt  <= 6'(LAT);
        cm_val  <= conv_binary_value;
      end
    end
  end

  assign conv_ready = !cm_busy && !force_nr;
  assign conv_done  = cm_done | inj_done;
  assign conv_bcd   = inj_done ? inj_bcd : cm_bcd;

  // scoreboard
  typedef struct { int id; logic [31:0] bcd; logic err; } exp_t;
  exp_t        sb[$];
  int          grant_log[$];
  logic [31:0] exp_bcd [N];
  logic        exp_err [N];
  logic        prev_acc = 1'b0;
  logic [DW-1:0] exp_op = '0;
  int          since_start = 0;
  int          n_resp = 0;

  // monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      prev_acc = 1'b0;
    end else begin
      exp_t e;
      int gid;
      if (conv_start) since_start = 0; else since_start++;
      if (prev_acc) begin
        check("start_after_accept", conv_start, 1);
        check("operand", conv_binary_value, exp_op);
      end else if (conv_start) begin
        check("spurious_start", conv_start, 0);
      end
      prev_acc = |req_ready;
      if (|req_ready) begin
        check("ready_onehot", $onehot(req_ready), 1);
        gid = 0;
        for (int i = 0; i < N; i++) if (req_ready[i]) gid = i;
        grant_log.push_back(gid);
        exp_op = req_data[gid*DW +: DW];
        e.id = gid; e.bcd = exp_bcd[gid]; e.err = exp_err[gid];
        sb.push_back(e);
      end
      if (|resp_valid) begin
        n_resp++;
        if (sb.size() == 0) begin
          check("unexpected_resp", resp_valid, 0);
        end else begin
          e = sb.pop_front();
          check("resp_id", resp_valid, 4'b1 << e.id);
          check("resp_grant_id", grant_id, e.id);
          check("resp_err", resp_err, e.err);
          check("resp_bcd", resp_bcd, e.bcd);
          if (e.err) check("timeout_latency", since_start, 128);
        end
      end
    end
  end

  // requester model: drop after accept, optional re-request after response
  int          rereq_left [N] = '{default: 0};
  logic [N-1:0] last_acc = '0;
  logic         last_start = 1'b0;

  task automatic step();
    logic [N-1:0] acc, rv;
    @(negedge clk);
    acc = req_ready; rv = resp_valid;
    last_acc = acc; last_start = conv_start;
    @(posedge clk); #1;
    req_valid = req_valid & ~acc;
    for (int i = 0; i < N; i++)
      if (rv[i] && rereq_left[i] > 0) begin
        req_valid[i] = 1'b1;
        rereq_left[i]--;
      end
  endtask

  task automatic request(int id, logic [DW-1:0] data, logic [31:0] bcd, logic err);
    exp_bcd[id] = bcd;
    exp_err[id] = err;
    req_data[id*DW +: DW] = data;
    req_valid[id] = 1'b1;
  endtask

  task automatic drain(int limit);
    int k;
    int pend;
    k = 0;
    pend = rereq_left[0] + rereq_left[1] + rereq_left[2] + rereq_left[3];
    while (k < limit && (sb.size() != 0 || req_valid != 0 || busy || pend != 0)) begin
      step();
      k++;
      pend = rereq_left[0] + rereq_left[1] + rereq_left[2] + rereq_left[3];
    end
    check("drain_budget", {sb.size() != 0, req_valid != 0, busy}, 0);
  endtask

  task automatic wait_start(int limit);
    int k;
    k = 0;
    last_start = 1'b0;
    while (k < limit && !last_start) begin step(); k++; end
    check("start_seen", last_start, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    grant_log.delete();
  endtask

  typedef struct { int id; logic [DW-1:0] data; logic [31:0] bcd; } vec_t;
  vec_t tbl [4];

  initial begin
    logic [31:0] last_bcd;
    int          resp_snap;
    logic [N-1:0] acc_any;
    int          exp_order [3];

    tbl[0] = '{0, 26'd43210,    32'h00043210};
    tbl[1] = '{1, 26'd7,        32'h00000007};
    tbl[2] = '{2, 26'd0,        32'h00000000};
    tbl[3] = '{3, 26'd67108863, 32'h67108863};
    for (int i = 0; i < N; i++) begin exp_bcd[i] = '0; exp_err[i] = 1'b0; end

    // reset state
    #3;
    check("reset_outputs", {req_ready, resp_valid, resp_err, resp_bcd, busy, grant_id,
                            conv_start, conv_binary_value}, 0);
    @(posedge clk); #1 rst = 1'b0;

    // single request
    grant_log.delete();
    request(0, 26'd162, 32'h00000162, 1'b0);
    drain(200);
    check("single_grants", grant_log.size(), 1);

    // round-robin from a fresh pointer
    do_reset();
    for (int i = 0; i < 4; i++) request(tbl[i].id, tbl[i].data, tbl[i].bcd, 1'b0);
    drain(400);
    check("rr_count", grant_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < grant_log.size()) check("rr_order", grant_log[i], tbl[i].id);

    // fairness: requester 1 re-requests while 3 pends
    grant_log.delete();
    rereq_left[1] = 1;
    request(1, 26'd55, 32'h00000055, 1'b0);
    request(3, 26'd9876, 32'h00009876, 1'b0);
    drain(400);
    exp_order = '{1, 3, 1};
    check("fair_count", grant_log.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < grant_log.size()) check("fair_order", grant_log[i], exp_order[i]);

    // timeout, then a normal request
    suppress = 1'b1;
    request(0, 26'd5, 32'h00000000, 1'b1);
    drain(400);
    suppress = 1'b0;
    request(2, 26'd12345, 32'h00012345, 1'b0);
    drain(200);

    // result holds, stray done in IDLE ignored
    last_bcd = resp_bcd;
    resp_snap = n_resp;
    repeat (5) step();
    inj_bcd = 32'h87654321; inj_done = 1'b1;
    step();
    inj_done = 1'b0;
    repeat (3) step();
    check("bcd_hold", resp_bcd, last_bcd);
    check("idle_done_ignored", n_resp, resp_snap);
    check("idle_not_busy", busy, 0);

    // done and watchdog expiry in the same cycle: done wins
    suppress = 1'b1;
    request(1, 26'd4, 32'h12345678, 1'b0);
    wait_start(20);
    repeat (126) step();
    inj_bcd = 32'h12345678; inj_done = 1'b1;
    step();
    inj_done = 1'b0;
    suppress = 1'b0;
    drain(200);

    // reset in the middle of WAIT
    request(3, 26'd777, 32'h00000777, 1'b0);
    wait_start(20);
    repeat (20) step();
    resp_snap = n_resp;
    #2 rst = 1'b1;
    #1;
    check("async_reset_outputs", {req_ready, resp_valid, resp_err, resp_bcd, busy, grant_id,
                                  conv_start, conv_binary_value}, 0);
    req_valid = '0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) step();
    check("no_resp_after_reset", n_resp, resp_snap);
    request(0, 26'd99, 32'h00000099, 1'b0);
    drain(200);

    // converter busy holds off the grant
    force_nr = 1'b1;
    request(2, 26'd31, 32'h00000031, 1'b0);
    acc_any = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      acc_any = acc_any | last_acc | {3'b0, last_start};
    end
    check("busy_no_grant", acc_any, 0);
    force_nr = 1'b0;
    step();
    check("grant_on_ready", last_acc, 4'b0100);
    drain(200);

    check("sb_empty_end", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
